// File: rtl/fwft_fifo_param.sv
// First-word-fall-through FIFO, valid/ready on both sides, any DEPTH >= 2.
// Define FWFT_FIFO_PEAK_EN to add the peak_clear/peak_count high-water mark.
module fwft_fifo_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 81,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4,
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      count,
  output logic                  almost_full,
  output logic                  almost_empty
`ifdef FWFT_FIFO_PEAK_EN
  ,
  input  logic                  peak_clear,
  output logic [CNT_W-1:0]      peak_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AEMPTY_THRESH);

  if (!(DEPTH >= 2 && AEMPTY_THRESH >= 0 && AEMPTY_THRESH < AFULL_THRESH &&
        AFULL_THRESH <= DEPTH)) begin : g_param_check
    $error("fwft_fifo_param: need DEPTH>=2 and 0<=AEMPTY_THRESH<AFULL_THRESH<=DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_next;
  logic                  push;
  logic                  pop;

  // Handshake and flags look only at registered count, so there is no
  // combinational path from out_ready to in_ready.
  always_comb begin
    in_ready     = (count != FULL_CNT);
    out_valid    = (count != '0);
    push         = in_valid & in_ready;
    pop          = out_valid & out_ready;
    out_data     = out_valid ? mem[rd_ptr] : '0;
    almost_full  = (count >= AF_CNT);
    almost_empty = (count <= AE_CNT);
  end

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset && push)
      mem[wr_ptr] <= in_data;
  end

  // Pointers wrap explicitly since DEPTH need not be a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      count <= count_next;
    end
  end

`ifdef FWFT_FIFO_PEAK_EN
  always_ff @(posedge clk) begin
    if (reset)
      peak_count <= '0;
    else if (peak_clear)
      peak_count <= count_next;
    else if (count_next > peak_count)
      peak_count <= count_next;
  end
`endif

endmodule

// File: tb/tb_fwft_fifo_param.sv
// Scoreboard bench for fwft_fifo_param: a queue model predicts occupancy,
// flags and head data; directed fill/drain/reset phases plus a random stream.
module tb_fwft_fifo_param;
  localparam int DW    = 8;
  localparam int DEPTH = 81;
  localparam int AF    = 77;
  localparam int AE    = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          almost_empty;
`ifdef FWFT_FIFO_PEAK_EN
  logic          peak_clear = 1'b0;
  logic [CW-1:0] peak_count;
  int            peak_model = 0;
`endif

  fwft_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
`ifdef FWFT_FIFO_PEAK_EN
    , .peak_clear(peak_clear), .peak_count(peak_count)
`endif
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int emitted = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare the DUT to the model state, then advance the model by
  // what the coming edge will do (pop the head, append the accepted word).
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
`ifdef FWFT_FIFO_PEAK_EN
      peak_model = 0;
`endif
    end else begin
      int sz;
      bit do_push, do_pop;
      sz = exp_q.size();
      check("count", int'(count), sz);
      check("in_ready", int'(in_ready), int'(sz != DEPTH));
      check("out_valid", int'(out_valid), int'(sz != 0));
      check("almost_full", int'(almost_full), int'(sz >= AF));
      check("almost_empty", int'(almost_empty), int'(sz <= AE));
      check("out_data", int'(out_data), (sz != 0) ? int'(exp_q[0]) : 0);
`ifdef FWFT_FIFO_PEAK_EN
      check("peak_count", int'(peak_count), peak_model);
`endif
      do_pop  = out_ready && (sz != 0);
      do_push = in_valid && (sz != DEPTH);
      if (do_pop) begin
        void'(exp_q.pop_front());
        emitted++;
      end
      if (do_push) exp_q.push_back(in_data);
`ifdef FWFT_FIFO_PEAK_EN
      if (peak_clear) peak_model = exp_q.size();
      else if (exp_q.size() > peak_model) peak_model = exp_q.size();
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) tick();
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("drain_count", int'(count), 0);
    tick();
  endtask

  initial begin
    int k;
    int cyc;
    // Reset values are checked by the monitor on the first free cycle.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Single word: one-cycle latency, then pop back to empty.
    in_valid = 1'b1;
    in_data = 8'h2A;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();

    // Fill 0..80, then one extra word that must be refused.
    for (int i = 0; i < DEPTH + 1; i++) begin
      in_valid = 1'b1;
      in_data = DW'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    check("full_count", int'(count), DEPTH);
    tick();

    // Drain to 40, then push and pop together for one cycle.
    out_ready = 1'b1;
    repeat (DEPTH - 40) tick();
    in_valid = 1'b1;
    in_data = 8'hAA;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("simul_count", int'(count), 40);
    check("simul_head", int'(out_data), 42);
    tick();
    drain();

    // Random stream of 300 words, i mod 256.
    k = 0;
    cyc = 0;
    emitted = 0;
    while ((k < 300 || exp_q.size() != 0) && cyc < 6000) begin
      bit acc;
      in_valid = (k < 300) && ($urandom_range(0, 99) < 70);
      in_data = DW'(k);
      out_ready = ($urandom_range(0, 99) < ((cyc / 400) % 2 == 0 ? 35 : 80));
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("random_words_sent", k, 300);
    check("random_words_out", emitted, 300);
    tick();

    // Reset with 30 words stored; none of them may appear afterwards.
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_data = DW'(8'h80 + i);
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_count", int'(count), 0);
    check("post_reset_valid", int'(out_valid), 0);
    tick();
    in_valid = 1'b1;
    in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("post_reset_head", int'(out_data), 8'h55);
    tick();
    drain();

`ifdef FWFT_FIFO_PEAK_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1;
      in_data = DW'(i);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("peak_after_fill", int'(peak_count), 50);
    tick();
    peak_clear = 1'b1;
    tick();
    peak_clear = 1'b0;
    @(negedge clk);
    check("peak_after_clear", int'(peak_count), 10);
    tick();
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
